// File: rtl/lcd_pkg.sv
// Shared types, sprite geometry, default panel timing and bitmap ROM
// for the LCD sprite engine.
package lcd_pkg;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef struct packed {
      logic        vis;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] color;
   } spr_attr_t;

   localparam int SPR_W = 16;
   localparam int SPR_H = 16;

   localparam int DEF_H_ACTIVE = 480;
   localparam int DEF_H_BP     = 43;
   localparam int DEF_H_FP     = 8;
   localparam int DEF_V_ACTIVE = 272;
   localparam int DEF_V_BP     = 12;
   localparam int DEF_V_FP     = 8;

   // Concentric squares; bit 15 is the leftmost pixel of the row.
   function automatic logic [15:0] spr_row(input logic [3:0] row);
      logic [15:0] bits;
      case (row)
         4'd0, 4'd15: bits = 16'hFFFF;
         4'd1, 4'd14: bits = 16'h8001;
         4'd2, 4'd13: bits = 16'hBFFD;
         4'd3, 4'd12: bits = 16'hA005;
         4'd4, 4'd11: bits = 16'hAFF5;
         4'd5, 4'd10: bits = 16'hA815;
         4'd6, 4'd9:  bits = 16'hABD5;
         default:     bits = 16'hAA55;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Horizontal/vertical scan counters with active-area decode,
// frame-start pulse and completed-frame counter.
module lcd_timing_gen
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_BP     = DEF_H_BP,
   parameter int H_FP     = DEF_H_FP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_BP     = DEF_V_BP,
   parameter int V_FP     = DEF_V_FP
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        active,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        wrap,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP;

   localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_LO   = 16'(H_BP);
   localparam logic [15:0] H_HI   = 16'(H_BP + H_ACTIVE);
   localparam logic [15:0] V_LO   = 16'(V_BP);
   localparam logic [15:0] V_HI   = 16'(V_BP + V_ACTIVE);

   logic [15:0] h_cnt;
   logic [15:0] v_cnt;
   logic        h_wrap;

   assign h_wrap = (h_cnt == H_LAST);
   assign wrap   = h_wrap && (v_cnt == V_LAST);

   assign active = (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                   (v_cnt >= V_LO) && (v_cnt < V_HI);

   assign x = h_cnt - H_LO;
   assign y = v_cnt - V_LO;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frame_start <= wrap;
         if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= wrap ? '0 : v_cnt + 16'd1;
         end else begin
            h_cnt <= h_cnt + 16'd1;
         end
         if (wrap)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/lcd_sprite_engine.sv
// N-sprite overlay renderer for RGB565 SYNC-DE panels with shadowed
// sprite attributes committed at frame start.
module lcd_sprite_engine
   import lcd_pkg::*;
#(
   parameter int          H_ACTIVE    = DEF_H_ACTIVE,
   parameter int          H_BP        = DEF_H_BP,
   parameter int          H_FP        = DEF_H_FP,
   parameter int          V_ACTIVE    = DEF_V_ACTIVE,
   parameter int          V_BP        = DEF_V_BP,
   parameter int          V_FP        = DEF_V_FP,
   parameter int          NUM_SPRITES = 4,
   parameter logic [15:0] BG_COLOR    = 16'h0000,
   localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic             PixelClk,
   input  logic             nRST,
   input  logic             spr_wr_en,
   input  logic [IDX_W-1:0] spr_wr_idx,
   input  logic [15:0]      spr_wr_x,
   input  logic [15:0]      spr_wr_y,
   input  logic [15:0]      spr_wr_color,
   input  logic             spr_wr_vis,
   output logic             LCD_DE,
   output logic [4:0]       LCD_R,
   output logic [5:0]       LCD_G,
   output logic [4:0]       LCD_B,
   output logic             frame_start,
   output logic [15:0]      frame_cnt
);

   logic        active;
   logic        wrap;
   logic [15:0] x;
   logic [15:0] y;

   lcd_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_BP     (H_BP),
      .H_FP     (H_FP),
      .V_ACTIVE (V_ACTIVE),
      .V_BP     (V_BP),
      .V_FP     (V_FP)
   ) u_timing (
      .clk         (PixelClk),
      .rst_n       (nRST),
      .active      (active),
      .x           (x),
      .y           (y),
      .wrap        (wrap),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt)
   );

   spr_attr_t shadow [NUM_SPRITES];
   spr_attr_t live   [NUM_SPRITES];
   spr_attr_t wr_attr;

   assign wr_attr = '{vis:   spr_wr_vis,
                      x:     spr_wr_x,
                      y:     spr_wr_y,
                      color: spr_wr_color};

   // live samples the pre-edge shadow, so a same-edge write waits a frame.
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow[i] <= '0;
            live[i]   <= '0;
         end
      end else begin
         if (wrap)
            live <= shadow;
         if (spr_wr_en && (int'(spr_wr_idx) < NUM_SPRITES))
            shadow[spr_wr_idx] <= wr_attr;
      end
   end

   logic [NUM_SPRITES-1:0] hit;

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
      logic [3:0]  col;
      logic [3:0]  row;
      logic [15:0] bits;
      logic        in_x;
      logic        in_y;

      assign col  = x[3:0] - live[i].x[3:0];
      assign row  = y[3:0] - live[i].y[3:0];
      assign bits = spr_row(row);

      assign in_x = (x >= live[i].x) &&
                    ({1'b0, x} < {1'b0, live[i].x} + 17'(SPR_W));
      assign in_y = (y >= live[i].y) &&
                    ({1'b0, y} < {1'b0, live[i].y} + 17'(SPR_H));

      assign hit[i] = live[i].vis && in_x && in_y && bits[~col];
   end

   logic [15:0] pix;

   always_comb begin
      pix = BG_COLOR;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit[i])
            pix = live[i].color;
      end
   end

   logic    de_q;
   rgb565_t rgb_q;

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         de_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         de_q  <= active;
         rgb_q <= active ? rgb565_t'(pix) : '0;
      end
   end

   assign LCD_DE = de_q;
   assign LCD_R  = rgb_q.r;
   assign LCD_G  = rgb_q.g;
   assign LCD_B  = rgb_q.b;

endmodule

// File: tb/tb_lcd_sprite_engine.sv
// Directed bench for lcd_sprite_engine: frame timing, sprite
// rendering, priority, shadow commit, clipping and async reset.
`timescale 1ns/1ps
module tb_lcd_sprite_engine;

   localparam int HA = 480, HB = 2, HF = 1;
   localparam int VA = 52,  VB = 1, VF = 1;
   localparam int HT = HA + HB + HF;
   localparam int VT = VA + VB + VF;
   localparam int FRAME = HT * VT;
   localparam int NPIX = HA * VA;
   localparam int FIRST_DE = VB * HT + HB + 1;

   logic        PixelClk = 1'b0;
   logic        nRST;
   logic        spr_wr_en;
   logic [1:0]  spr_wr_idx;
   logic [15:0] spr_wr_x, spr_wr_y, spr_wr_color;
   logic        spr_wr_vis;
   logic        LCD_DE;
   logic [4:0]  LCD_R;
   logic [5:0]  LCD_G;
   logic [4:0]  LCD_B;
   logic        frame_start;
   logic [15:0] frame_cnt;

   always #5 PixelClk = ~PixelClk;

   lcd_sprite_engine #(
      .H_ACTIVE(HA), .H_BP(HB), .H_FP(HF),
      .V_ACTIVE(VA), .V_BP(VB), .V_FP(VF),
      .NUM_SPRITES(4), .BG_COLOR(16'h0000)
   ) dut (
      .PixelClk     (PixelClk),
      .nRST         (nRST),
      .spr_wr_en    (spr_wr_en),
      .spr_wr_idx   (spr_wr_idx),
      .spr_wr_x     (spr_wr_x),
      .spr_wr_y     (spr_wr_y),
      .spr_wr_color (spr_wr_color),
      .spr_wr_vis   (spr_wr_vis),
      .LCD_DE       (LCD_DE),
      .LCD_R        (LCD_R),
      .LCD_G        (LCD_G),
      .LCD_B        (LCD_B),
      .frame_start  (frame_start),
      .frame_cnt    (frame_cnt)
   );

   typedef struct {
      int          x;
      int          y;
      logic [15:0] color;
      bit          vis;
   } spr_t;

   typedef struct {
      int          frm;
      int          x;
      int          y;
      logic [15:0] exp;
      string       name;
   } vec_t;

   spr_t        mdl [3][4];
   logic [15:0] fb  [3][NPIX];
   vec_t        vecs [$];

   int errors = 0;
   int checks = 0;
   int de_cnt, run_len, runs, bad_runs, fs_cnt, fs_at, first_de, idle_bad;

   function automatic logic [15:0] cur_rgb();
      return {LCD_R, LCD_G, LCD_B};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   function automatic bit ring_on(input int r, input int c);
      int m = r;
      if (c < m) m = c;
      if (15 - r < m) m = 15 - r;
      if (15 - c < m) m = 15 - c;
      return (m % 2) == 0;
   endfunction

   function automatic logic [15:0] model(input int f, input int x,
                                         input int y);
      for (int i = 0; i < 4; i++) begin
         if (mdl[f][i].vis &&
             x >= mdl[f][i].x && x < mdl[f][i].x + 16 &&
             y >= mdl[f][i].y && y < mdl[f][i].y + 16 &&
             ring_on(y - mdl[f][i].y, x - mdl[f][i].x))
            return mdl[f][i].color;
      end
      return 16'h0000;
   endfunction

   task automatic set_wr(input int idx, input int x, input int y,
                         input logic [15:0] c, input bit v);
      spr_wr_en    = 1'b1;
      spr_wr_idx   = 2'(idx);
      spr_wr_x     = 16'(x);
      spr_wr_y     = 16'(y);
      spr_wr_color = c;
      spr_wr_vis   = v;
   endtask

   task automatic clr_wr();
      spr_wr_en = 1'b0;
   endtask

   task automatic stimulus(input int f, input int c);
      if (f == 0) begin
         if (c == 1) set_wr(0, 0, 0, 16'h07E0, 1'b1);
         if (c == 2) set_wr(1, 100, 50, 16'h001F, 1'b1);
         if (c == 3) clr_wr();
         if (c == FRAME - 1) set_wr(3, 470, 20, 16'hF81F, 1'b1);
         if (c == FRAME) clr_wr();
      end else if (f == 1) begin
         if (c == 5000) set_wr(0, 100, 50, 16'hF800, 1'b1);
         if (c == 5001) set_wr(2, 200, 24, 16'hFFE0, 1'b1);
         if (c == 5002) clr_wr();
      end
   endtask

   task automatic run_frame(input int f);
      bit prev_de = 1'b0;
      de_cnt = 0; run_len = 0; runs = 0; bad_runs = 0;
      fs_cnt = 0; fs_at = -1; first_de = -1; idle_bad = 0;
      for (int c = 1; c <= FRAME; c++) begin
         @(negedge PixelClk);
         stimulus(f, c);
         if (frame_start) begin
            fs_cnt++;
            fs_at = c;
         end
         if (LCD_DE) begin
            if (first_de < 0) first_de = c;
            if (de_cnt < NPIX) fb[f][de_cnt] = cur_rgb();
            de_cnt++;
            run_len++;
         end else begin
            if (cur_rgb() != 16'h0000) idle_bad++;
            if (prev_de) begin
               runs++;
               if (run_len != HA) bad_runs++;
               run_len = 0;
            end
         end
         prev_de = LCD_DE;
      end
   endtask

   task automatic frame_checks(input int f);
      int mism = 0;
      chk($sformatf("f%0d_de_total", f), de_cnt, NPIX);
      chk($sformatf("f%0d_lines", f), runs, VA);
      chk($sformatf("f%0d_bad_line_len", f), bad_runs, 0);
      chk($sformatf("f%0d_first_de_cycle", f), first_de, FIRST_DE);
      chk($sformatf("f%0d_fs_pulses", f), fs_cnt, 1);
      chk($sformatf("f%0d_fs_cycle", f), fs_at, FRAME);
      chk($sformatf("f%0d_frame_cnt", f), int'(frame_cnt), f + 1);
      chk($sformatf("f%0d_rgb_idle", f), idle_bad, 0);
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++)
            if (fb[f][y * HA + x] !== model(f, x, y)) mism++;
      chk($sformatf("f%0d_model_mism", f), mism, 0);
   endtask

   initial begin
      int w, nz, n;

      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 4; i++)
            mdl[f][i] = '{x: 0, y: 0, color: 16'h0000, vis: 1'b0};
      mdl[1][0] = '{x: 0,   y: 0,  color: 16'h07E0, vis: 1'b1};
      mdl[1][1] = '{x: 100, y: 50, color: 16'h001F, vis: 1'b1};
      mdl[2][0] = '{x: 100, y: 50, color: 16'hF800, vis: 1'b1};
      mdl[2][1] = '{x: 100, y: 50, color: 16'h001F, vis: 1'b1};
      mdl[2][2] = '{x: 200, y: 24, color: 16'hFFE0, vis: 1'b1};
      mdl[2][3] = '{x: 470, y: 20, color: 16'hF81F, vis: 1'b1};

      vecs.push_back('{1, 0,   0,  16'h07E0, "f1_first_px"});
      vecs.push_back('{1, 1,   1,  16'h0000, "f1_px_1_1"});
      vecs.push_back('{1, 15,  15, 16'h07E0, "f1_px_15_15"});
      vecs.push_back('{1, 16,  0,  16'h0000, "f1_px_16_0"});
      vecs.push_back('{1, 100, 50, 16'h001F, "f1_px_100_50"});
      vecs.push_back('{1, 200, 24, 16'h0000, "f1_no_spr2"});
      vecs.push_back('{1, 470, 20, 16'h0000, "f1_no_spr3"});
      vecs.push_back('{2, 100, 50, 16'hF800, "f2_priority"});
      vecs.push_back('{2, 101, 51, 16'h0000, "f2_transparent"});
      vecs.push_back('{2, 0,   0,  16'h0000, "f2_spr0_moved"});
      vecs.push_back('{2, 200, 23, 16'h0000, "f2_spr2_above"});
      vecs.push_back('{2, 200, 24, 16'hFFE0, "f2_spr2_top"});
      vecs.push_back('{2, 202, 26, 16'hFFE0, "f2_spr2_ring2"});
      vecs.push_back('{2, 201, 25, 16'h0000, "f2_spr2_ring1"});
      vecs.push_back('{2, 470, 20, 16'hF81F, "f2_spr3_left"});
      vecs.push_back('{2, 479, 20, 16'hF81F, "f2_spr3_clip"});
      vecs.push_back('{2, 479, 21, 16'h0000, "f2_spr3_r1c9"});
      vecs.push_back('{2, 477, 22, 16'hF81F, "f2_spr3_r2c7"});
      vecs.push_back('{2, 0,   20, 16'h0000, "f2_no_wrap_x0"});
      vecs.push_back('{2, 5,   20, 16'h0000, "f2_no_wrap_x5"});

      nRST = 1'b0;
      spr_wr_en = 1'b0; spr_wr_idx = '0; spr_wr_x = '0;
      spr_wr_y = '0; spr_wr_color = '0; spr_wr_vis = 1'b0;
      repeat (3) @(negedge PixelClk);
      chk("rst_de", int'(LCD_DE), 0);
      chk("rst_rgb", int'(cur_rgb()), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      nRST = 1'b1;

      for (int f = 0; f < 3; f++) begin
         run_frame(f);
         frame_checks(f);
      end

      foreach (vecs[i])
         chk(vecs[i].name, int'(fb[vecs[i].frm][vecs[i].y * HA + vecs[i].x]),
             int'(vecs[i].exp));

      w = 0;
      while (!LCD_DE && w < 4 * HT) begin
         @(negedge PixelClk);
         w++;
      end
      chk("pre_reset_de", int'(LCD_DE), 1);
      repeat (100) @(negedge PixelClk);
      #2 nRST = 1'b0;
      #1;
      chk("async_de", int'(LCD_DE), 0);
      chk("async_rgb", int'(cur_rgb()), 0);
      chk("async_frame_cnt", int'(frame_cnt), 0);
      repeat (3) @(posedge PixelClk);
      @(negedge PixelClk);
      chk("held_de", int'(LCD_DE), 0);
      nRST = 1'b1;

      first_de = -1; nz = 0; n = 0;
      for (int c = 1; c <= FIRST_DE + 20; c++) begin
         @(negedge PixelClk);
         if (LCD_DE) begin
            if (first_de < 0) first_de = c;
            if (n < 16 && cur_rgb() != 16'h0000) nz++;
            n++;
         end
      end
      chk("post_rst_first_de", first_de, FIRST_DE);
      chk("post_rst_hidden", nz, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
